// File: rtl/matrix_pkg.sv
// Shared types and helpers for the 8x8 LED matrix scan path.
// Pure declarations: no clocked logic, no latency.
// No flow control lives here.
package matrix_pkg;

   localparam int MATRIX_W = 8;
   localparam int MATRIX_H = 8;
   localparam int PIX_N    = MATRIX_W * MATRIX_H;
   localparam int ROW_W    = $clog2(MATRIX_H);

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   // Flat bit position of pixel (x,y) inside a frame word.
   function automatic int pix_index(input int x, input int y);
      return y * MATRIX_W + x;
   endfunction

   // Row-select pattern with exactly one row asserted in the requested polarity.
   function automatic logic [MATRIX_H-1:0] row_onehot(input logic [ROW_W-1:0] row,
                                                      input logic active_low);
      logic [MATRIX_H-1:0] oh;
      oh = {{(MATRIX_H-1){1'b0}}, 1'b1} << row;
      return active_low ? ~oh : oh;
   endfunction

endpackage

// File: rtl/matrix_frame_buffer.sv
// Double buffer: back register fed by a valid/ready handshake, front register shown on the matrix.
// Latency: a frame lands in back one edge after transfer; reaches front on the next swap strobe.
// Backpressure: frame_ready is low while back holds an unshown frame; it reopens after the swap.
module matrix_frame_buffer
   import matrix_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIX_N-1:0] frame_in,
   input  logic             frame_valid,
   input  logic             swap,
   output logic             frame_ready,
   output logic [PIX_N-1:0] front
);

   logic [PIX_N-1:0] back;
   logic             pending;

   assign frame_ready = !pending;

   // Accept into back when empty; promote back to front on a frame-boundary strobe.
   // The two branches never compete: acceptance needs pending low, the swap needs it high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         back    <= '0;
         front   <= '0;
         pending <= 1'b0;
      end else if (frame_valid && !pending) begin
         back    <= frame_in;
         pending <= 1'b1;
      end else if (swap && pending) begin
         front   <= back;
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/matrix_scan_driver.sv
// Scans a double-buffered 8x8 frame onto a multiplexed LED matrix one row at a time.
// Latency: outputs are registered one edge behind the scan FSM; row 0 is driven on the 3rd edge after reset by default.
// Backpressure: frame_ready drops while a frame waits for the next frame boundary; scan_en low freezes and blanks.
module matrix_scan_driver
   import matrix_pkg::*;
#(
   parameter int DWELL_CYCLES   = 16,
   parameter int BLANK_CYCLES   = 2,
   parameter bit ROW_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                scan_en,
   input  logic [PIX_N-1:0]    frame_in,
   input  logic                frame_valid,
   output logic                frame_ready,
   output logic [MATRIX_H-1:0] row_sel,
   output logic [MATRIX_W-1:0] col_data,
   output logic                frame_start
);

   localparam int CNT_SPAN = (DWELL_CYCLES > BLANK_CYCLES)
                           ? ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2)
                           : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
   localparam int CW = $clog2(CNT_SPAN);

   // Terminal counts; the blank one is unused when blanking is skipped, so clamp it at 0.
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam bit            SKIP_BLANK = (BLANK_CYCLES == 0);

   localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(MATRIX_H - 1);
   localparam logic [MATRIX_H-1:0] ROW_IDLE = ROW_ACTIVE_LOW ? {MATRIX_H{1'b1}} : {MATRIX_H{1'b0}};

   scan_state_t      state, state_nxt;
   logic [ROW_W-1:0] row, row_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             boundary;
   logic [PIX_N-1:0] front;

   matrix_frame_buffer u_fb (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .swap        (boundary),
      .frame_ready (frame_ready),
      .front       (front)
   );

   // Scan position register: state, current row and clocks spent in the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BLANK;
         row   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         row   <= row_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next scan position; everything holds while scan_en is low so dwell time is preserved.
   always_comb begin
      state_nxt = state;
      row_nxt   = row;
      cnt_nxt   = cnt;
      boundary  = 1'b0;
      if (scan_en) begin
         unique case (state)
            BLANK: begin
               if (SKIP_BLANK || cnt == BLANK_LAST) begin
                  state_nxt = DRIVE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            DRIVE: begin
               if (cnt == DWELL_LAST) begin
                  cnt_nxt   = '0;
                  row_nxt   = row + ROW_W'(1);
                  boundary  = (row == LAST_ROW);
                  state_nxt = SKIP_BLANK ? DRIVE : BLANK;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         endcase
      end
   end

   // Registered pin drive: light the current row from the front buffer, otherwise all inactive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_sel     <= ROW_IDLE;
         col_data    <= '0;
         frame_start <= 1'b0;
      end else if (scan_en && state == DRIVE) begin
         row_sel     <= row_onehot(row, ROW_ACTIVE_LOW);
         col_data    <= front[pix_index(0, int'(row)) +: MATRIX_W];
         frame_start <= (row == '0) && (cnt == '0);
      end else begin
         row_sel     <= ROW_IDLE;
         col_data    <= '0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: a default instance and a no-blank, single-dwell, active-high instance.
// Both are compared every clock against an arithmetic model of the scan timeline and double buffer.
// Producers hold valid until a transfer, as a well-behaved upstream would.
module tb_matrix_scan_driver;

   localparam int B_A = 2, D_A = 16, B_B = 0, D_B = 1;
   localparam bit AL_A = 1'b1, AL_B = 1'b0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        en  [2];
   logic        val [2];
   logic [63:0] fin [2];
   logic [7:0]  rs  [2];
   logic [7:0]  col [2];
   logic        fs  [2];
   logic        rdy [2];

   matrix_scan_driver #(.DWELL_CYCLES(D_A), .BLANK_CYCLES(B_A), .ROW_ACTIVE_LOW(AL_A)) u_a (
      .clk(clk), .rst_n(rst_n), .scan_en(en[0]), .frame_in(fin[0]), .frame_valid(val[0]),
      .frame_ready(rdy[0]), .row_sel(rs[0]), .col_data(col[0]), .frame_start(fs[0]));

   matrix_scan_driver #(.DWELL_CYCLES(D_B), .BLANK_CYCLES(B_B), .ROW_ACTIVE_LOW(AL_B)) u_b (
      .clk(clk), .rst_n(rst_n), .scan_en(en[1]), .frame_in(fin[1]), .frame_valid(val[1]),
      .frame_ready(rdy[1]), .row_sel(rs[1]), .col_data(col[1]), .frame_start(fs[1]));

   int n_cmp = 0, n_fail = 0, edge_n = 0;

   // Model state: enabled edges seen since reset, front/back frames, pending flag.
   int          adv [2];
   logic [63:0] fm  [2];
   logic [63:0] bm  [2];
   bit          pm  [2];
   bit          xfer[2];
   bit          swp [2];

   function automatic int pb(int i); return (i == 0) ? B_A : B_B; endfunction
   function automatic int pd(int i); return (i == 0) ? D_A : D_B; endfunction
   function automatic bit pal(int i); return (i == 0) ? AL_A : AL_B; endfunction

   // Expected {row_sel, col_data, frame_start} at an edge, from the scan position before that edge.
   // Without blanking the reset state still occupies one (dark) clock before row 0.
   function automatic logic [16:0] exp_vec(int b, int d, bit al, int p, logic [63:0] fr, logic e);
      logic [7:0] r_s, c;
      logic       f;
      int off, q, rp, w, row, o;
      r_s = al ? 8'hFF : 8'h00;
      c = 8'h00;
      f = 1'b0;
      off = (b == 0) ? 1 : 0;
      if (e && p >= off) begin
         q = p - off; rp = b + d; w = q % (8 * rp); row = w / rp; o = w % rp;
         if (o >= b) begin
            r_s = al ? ~(8'h01 << row) : (8'h01 << row);
            c = fr[row*8 +: 8];
            f = (row == 0 && o == b);
         end
      end
      return {r_s, c, f};
   endfunction

   // True on the edge that finishes the last drive clock of row 7.
   function automatic bit at_boundary(int b, int d, int p, logic e);
      int off, rp;
      off = (b == 0) ? 1 : 0;
      rp = b + d;
      return e && p >= off && ((p - off) % (8 * rp)) == (8 * rp - 1);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         adv[i] = 0; fm[i] = '0; bm[i] = '0; pm[i] = 1'b0; xfer[i] = 1'b0; swp[i] = 1'b0;
      end
      edge_n = 0;
   endtask

   // One clock: advance the model on the edge, then compare both instances 1 time unit later.
   task automatic step();
      logic [16:0] e [2];
      bit po;
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 2; i++) begin
         e[i] = exp_vec(pb(i), pd(i), pal(i), adv[i], fm[i], en[i]);
         po = pm[i];
         xfer[i] = val[i] && !po;
         swp[i]  = at_boundary(pb(i), pd(i), adv[i], en[i]) && po;
         if (xfer[i]) begin bm[i] = fin[i]; pm[i] = 1'b1; end
         if (swp[i])  begin fm[i] = bm[i];  pm[i] = 1'b0; end
         if (en[i]) adv[i]++;
      end
      #1;
      chk("scan_a", 32'({rs[0], col[0], fs[0], rdy[0]}), 32'({e[0], !pm[0]}));
      chk("scan_b", 32'({rs[1], col[1], fs[1], rdy[1]}), 32'({e[1], !pm[1]}));
   endtask

   task automatic wait_rs(logic [7:0] v, int lim, string nm);
      int n = 0;
      while (rs[0] !== v && n < lim) begin step(); n++; end
      if (rs[0] !== v) chk(nm, 32'(rs[0]), 32'(v));
   endtask

   task automatic push_a(logic [63:0] f);
      int n = 0;
      val[0] = 1'b1; fin[0] = f;
      do begin step(); n++; end while (!xfer[0] && n < 400);
      if (!xfer[0]) chk("push_timeout", 32'(xfer[0]), 32'd1);
      val[0] = 1'b0;
   endtask

   typedef struct {
      int         edge_no;
      logic [7:0] rs;
      logic [7:0] col;
      logic       fs;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, nb, nfs, ps;
      // Idle timeline of the default instance with an empty front buffer.
      tbl[0]  = '{1,   8'hFF, 8'h00, 1'b0};
      tbl[1]  = '{2,   8'hFF, 8'h00, 1'b0};
      tbl[2]  = '{3,   8'hFE, 8'h00, 1'b1};
      tbl[3]  = '{4,   8'hFE, 8'h00, 1'b0};
      tbl[4]  = '{18,  8'hFE, 8'h00, 1'b0};
      tbl[5]  = '{19,  8'hFF, 8'h00, 1'b0};
      tbl[6]  = '{20,  8'hFF, 8'h00, 1'b0};
      tbl[7]  = '{21,  8'hFD, 8'h00, 1'b0};
      tbl[8]  = '{39,  8'hFB, 8'h00, 1'b0};
      tbl[9]  = '{57,  8'hF7, 8'h00, 1'b0};
      tbl[10] = '{129, 8'h7F, 8'h00, 1'b0};
      tbl[11] = '{144, 8'h7F, 8'h00, 1'b0};
      tbl[12] = '{145, 8'hFF, 8'h00, 1'b0};
      tbl[13] = '{147, 8'hFE, 8'h00, 1'b1};

      for (int i = 0; i < 2; i++) begin en[i] = 1'b1; val[i] = 1'b0; fin[i] = '0; end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_a", 32'({rs[0], col[0], fs[0], rdy[0]}), 32'({8'hFF, 8'h00, 1'b0, 1'b1}));
      chk("reset_b", 32'({rs[1], col[1], fs[1], rdy[1]}), 32'({8'h00, 8'h00, 1'b0, 1'b1}));
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         while (edge_n < tbl[k].edge_no) step();
         chk("idle_tbl", 32'({rs[0], col[0], fs[0]}), 32'({tbl[k].rs, tbl[k].col, tbl[k].fs}));
      end

      // No-blank instance: a row every clock, never dark, frame_start every 8 clocks.
      nb = 0; nfs = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (rs[1] == 8'h00) nb++;
         if (fs[1]) nfs++;
      end
      chk("b_dark_clocks", 32'(nb), 32'd0);
      chk("b_frame_starts", 32'(nfs), 32'd10);

      // Frame sent mid-row 3: ready drops, shown only from the next frame's row 1.
      wait_rs(8'hFF, 40, "find_blank");
      wait_rs(8'hF7, 200, "find_row3");
      repeat (5) step();
      val[0] = 1'b1; fin[0] = 64'h0000_0000_0000_0F00;
      step();
      val[0] = 1'b0;
      chk("ready_drop", 32'(rdy[0]), 32'd0);
      n = 0;
      do begin step(); n++; end while (!fs[0] && n < 300);
      chk("swap_fs", 32'(fs[0]), 32'd1);
      repeat (18) step();
      chk("row1_pixels", 32'({rs[0], col[0]}), 32'({8'hFD, 8'h0F}));
      chk("ready_back", 32'(rdy[0]), 32'd1);

      // Second frame held valid while the first is pending: accepted the edge after the swap.
      push_a(64'h8100_0000_0000_00C3);
      val[0] = 1'b1; fin[0] = 64'h00FF_0000_0000_3C00;
      n = 0; ps = 0;
      do begin ps = swp[0]; step(); n++; end while (!xfer[0] && n < 400);
      val[0] = 1'b0;
      chk("accept_after_swap", 32'({xfer[0], ps[0]}), 32'b11);
      repeat (300) step();

      // Freeze mid-row 5 after 7 dwell clocks; 9 remain on resume.
      wait_rs(8'hFF, 40, "find_blank5");
      wait_rs(8'hDF, 200, "find_row5");
      repeat (6) step();
      en[0] = 1'b0;
      nb = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (rs[0] == 8'hFF && col[0] == 8'h00 && !fs[0]) nb++;
      end
      chk("freeze_dark", 32'(nb), 32'd20);
      en[0] = 1'b1;
      n = 0;
      step();
      while (rs[0] == 8'hDF && n < 40) begin n++; step(); end
      chk("resume_dwell", 32'(n), 32'd9);

      // Reset mid-DRIVE with a frame pending.
      push_a(64'hDEAD_BEEF_0123_4567);
      wait_rs(8'hFF, 40, "find_blank_r");
      n = 0;
      while (rs[0] == 8'hFF && n < 10) begin step(); n++; end
      repeat (2) step();
      chk("pending_before_rst", 32'(rdy[0]), 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_a", 32'({rs[0], col[0], fs[0], rdy[0]}), 32'({8'hFF, 8'h00, 1'b0, 1'b1}));
      chk("async_rst_b", 32'({rs[1], col[1], fs[1], rdy[1]}), 32'({8'h00, 8'h00, 1'b0, 1'b1}));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      chk("restart_row0", 32'({rs[0], col[0], fs[0]}), 32'({8'hFE, 8'h00, 1'b1}));
      repeat (150) step();

      // Randomized enables and frame traffic on both instances.
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < 2; i++) begin
            en[i] = ($urandom_range(0, 15) != 0);
            if (!val[i] && $urandom_range(0, 7) == 0) begin
               val[i] = 1'b1;
               fin[i] = {$urandom, $urandom};
            end
         end
         step();
         for (int i = 0; i < 2; i++) if (xfer[i]) val[i] = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
